// File: rtl/regfile_writeback.sv
// Register-file write-back stage: arbitrates ALU and load results onto the
// single write port, formats load data, and tracks pending destinations.
module regfile_writeback #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  logic [AW-1:0]   lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_signed_i,
    input  logic [1:0]      lsu_byte_off_i,
    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_rd_i,
    output logic            reg_wr_en_o,
    output logic [AW-1:0]   rd_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [NREG-1:0] busy_o
);

    // High when the LSU wins the next conflict; flips after every conflict.
    logic            ptr_lsu;
    logic            conflict;
    logic            alu_acc;
    logic            lsu_acc;
    logic            acc;
    logic [AW-1:0]   acc_rd;
    logic [XLEN-1:0] acc_data;
    logic [XLEN-1:0] load_data;
    logic [NREG-1:0] busy_nxt;

    // Extract the addressed lane of the memory word and extend it to XLEN.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] data,
        input logic [1:0]      size,
        input logic            sgn,
        input logic [1:0]      off
    );
        logic [7:0]  lane8;
        logic [15:0] lane16;
        logic [XLEN-1:0] res;
        lane8  = data[8*off +: 8];
        lane16 = data[16*off[1] +: 16];
        case (size)
            2'd0:    res = {{(XLEN-8){sgn & lane8[7]}}, lane8};
            2'd1:    res = {{(XLEN-16){sgn & lane16[15]}}, lane16};
            default: res = data;
        endcase
        return res;
    endfunction

    // Grant logic: single valid source always wins, pointer breaks ties.
    // Readies are forced low while reset is asserted.
    always_comb begin
        conflict    = alu_valid_i & lsu_valid_i;
        alu_ready_o = rst_ni & alu_valid_i & (~lsu_valid_i | ~ptr_lsu);
        lsu_ready_o = rst_ni & lsu_valid_i & (~alu_valid_i | ptr_lsu);
        alu_acc     = alu_ready_o;
        lsu_acc     = lsu_ready_o;
        acc         = alu_acc | lsu_acc;
        load_data   = format_load(lsu_data_i, lsu_size_i, lsu_signed_i, lsu_byte_off_i);
        acc_rd      = lsu_acc ? lsu_rd_i : alu_rd_i;
        acc_data    = lsu_acc ? load_data : alu_data_i;
    end

    // Scoreboard update: a completing write clears its bit, a new issue sets
    // it, and the issue is applied last so the newer owner keeps the bit.
    always_comb begin
        busy_nxt = busy_o;
        for (int i = 1; i < NREG; i++) begin
            if (acc && acc_rd == AW'(i)) begin
                busy_nxt[i] = 1'b0;
            end
            if (iss_valid_i && iss_rd_i == AW'(i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Round-robin pointer flips only on a contested grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_lsu <= 1'b1;
        end else if (conflict) begin
            ptr_lsu <= ~ptr_lsu;
        end
    end

    // Registered write port; address/data hold when no write is produced.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_wr_en_o <= 1'b0;
            rd_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            reg_wr_en_o <= acc && (acc_rd != '0);
            if (acc && (acc_rd != '0)) begin
                rd_addr_o <= acc_rd;
                wr_data_o <= acc_data;
            end
        end
    end

    // Pending-destination scoreboard register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_nxt;
        end
    end

endmodule
